// File: rtl/uart_pkg.sv
// uart_pkg: constants and feeder state type shared by the UART transmitter blocks
//   UART_DATA_W     - width of a transmitted word
//   UART_FRAME_BITS - bit periods per frame (start + 9 data + parity + stop)
//   feeder_state_e  - IDLE / SEND / GAP states of uart_tx_feeder
package uart_pkg;
   localparam int UART_DATA_W     = 9;
   localparam int UART_FRAME_BITS = 12;
   typedef enum logic [1:0] {IDLE, SEND, GAP} feeder_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with push/pop/flush and registered occupancy
//   clk_i, rst_i       - clock, synchronous active-high reset
//   push_i, data_i     - write request and word (refused when full or flushing)
//   pop_i, data_o      - read request and head word (data_o shows the head combinationally)
//   flush_i            - drop all queued words on the next edge
//   full_o, empty_o    - derived from the registered count
//   count_o            - registered number of queued words
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int W     = UART_DATA_W,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [W-1:0]           data_i,
   output logic [W-1:0]           data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;
   assign full_o  = count_q == (AW+1)'(DEPTH);
   assign empty_o = count_q == '0;
   // full blocks a push even when a pop frees a slot in the same cycle
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o;
   assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= wr_ptr_q;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk_i) if (do_push) mem_q[wr_ptr_q] <= data_i;
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers words and paces them to the UART, one frame then an idle gap
//   txclk_i, reset_i         - UART tx clock, synchronous active-high reset
//   in_valid_i, in_data_i    - producer word, taken when in_ready_o is high
//   in_ready_o               - FIFO has room (registered count < DEPTH)
//   flush_i                  - discard queued words; the frame in flight continues
//   tx_enable_o, tx_data_o   - to the UART; data stable while enable is high
//   busy_o                   - sending a frame or in the inter-frame gap
//   fifo_count_o             - registered number of queued words
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int FRAME_BITS   = UART_FRAME_BITS,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                   txclk_i,
   input  logic                   reset_i,
   input  logic                   in_valid_i,
   input  logic [UART_DATA_W-1:0] in_data_i,
   output logic                   in_ready_o,
   input  logic                   flush_i,
   output logic                   tx_enable_o,
   output logic [UART_DATA_W-1:0] tx_data_o,
   output logic                   busy_o,
   output logic [$clog2(DEPTH):0] fifo_count_o
);
   localparam int FRAME_LEN = FRAME_BITS * CLKS_PER_BIT;
   localparam int FW        = $clog2(FRAME_LEN + 1);
   localparam int GW        = $clog2(GAP_CYCLES + 1);
   feeder_state_e          state_q;
   logic [FW-1:0]          frame_cnt_q;
   logic [GW-1:0]          gap_cnt_q;
   logic                   tx_enable_q;
   logic [UART_DATA_W-1:0] tx_data_q, head;
   logic                   full, empty, pop;
   // pop only from IDLE and only on the registered count, so a word pushed
   // this cycle is never popped in the same cycle
   assign pop         = state_q == IDLE && !empty;
   assign in_ready_o  = !full;
   assign busy_o      = state_q != IDLE;
   assign tx_enable_o = tx_enable_q;
   assign tx_data_o   = tx_data_q;
   uart_sync_fifo #(.W(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (txclk_i),
      .rst_i   (reset_i),
      .push_i  (in_valid_i),
      .pop_i   (pop),
      .flush_i (flush_i),
      .data_i  (in_data_i),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count_o)
   );
   always_ff @(posedge txclk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         gap_cnt_q   <= '0;
         tx_enable_q <= 1'b0;
         tx_data_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               tx_enable_q <= pop;
               if (pop) begin
                  tx_data_q   <= head;
                  frame_cnt_q <= '0;
                  state_q     <= SEND;
               end
            end
            SEND: begin
               frame_cnt_q <= frame_cnt_q + FW'(1);
               if (frame_cnt_q == FW'(FRAME_LEN - 1)) begin
                  tx_enable_q <= 1'b0;
                  gap_cnt_q   <= '0;
                  state_q     <= GAP;
               end
            end
            GAP: begin
               tx_enable_q <= 1'b0;
               gap_cnt_q   <= gap_cnt_q + GW'(1);
               if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: random and directed stimulus against a queue/timer reference model with a frame scoreboard
module tb_uart_tx_feeder;
   localparam int DEPTH  = 8;
   localparam int CPB    = 2;
   localparam int FB     = 12;
   localparam int GAP    = 2;
   localparam int FL     = FB * CPB;
   localparam int PERIOD = FL + GAP + 1;

   logic       txclk = 0, reset = 1, in_valid = 0, flush = 0;
   logic [8:0] in_data = '0;
   logic       in_ready, tx_enable, busy;
   logic [8:0] tx_data;
   logic [3:0] fifo_count;

   int         total = 0, bad = 0, frames = 0;
   bit         started = 0;
   logic [8:0] mq[$];
   logic [8:0] expq[$];
   int         left = 0;
   logic [8:0] cur = '0;

   always #5 txclk = ~txclk;

   uart_tx_feeder #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CYCLES(GAP)) dut (
      .txclk_i      (txclk),
      .reset_i      (reset),
      .in_valid_i   (in_valid),
      .in_data_i    (in_data),
      .in_ready_o   (in_ready),
      .flush_i      (flush),
      .tx_enable_o  (tx_enable),
      .tx_data_o    (tx_data),
      .busy_o       (busy),
      .fifo_count_o (fifo_count)
   );

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference: a queue of words plus a countdown of remaining busy cycles after each pop
   initial begin : model
      bit p, a;
      forever begin
         @(posedge txclk);
         if (reset) begin
            mq.delete();
            left = 0;
            cur  = '0;
         end else begin
            p = left == 0 && mq.size() > 0;
            a = in_valid && mq.size() < DEPTH && !flush;
            if (p) begin
               cur = mq.pop_front();
               expq.push_back(cur);
               left = FL + GAP;
            end else if (left > 0) left--;
            if (flush) mq.delete();
            else if (a) mq.push_back(in_data);
         end
      end
   end

   initial begin : monitor
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge txclk);
         if (started) begin
            chk("tx_enable", int'(tx_enable), int'(left > GAP));
            chk("busy", int'(busy), int'(left > 0));
            chk("fifo_count", int'(fifo_count), mq.size());
            chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
            chk("tx_data", int'(tx_data), int'(cur));
            if (tx_enable && !prev) begin
               frames++;
               chk("sb_has_word", int'(expq.size() > 0), 1);
               if (expq.size() > 0) chk("frame_word", int'(tx_data), int'(expq.pop_front()));
            end
         end
         prev = tx_enable;
      end
   end

   task automatic step(bit v, logic [8:0] d, bit f, bit r);
      in_valid = v;
      in_data  = d;
      flush    = f;
      reset    = r;
      @(posedge txclk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) step(0, '0, 0, 0);
   endtask

   task automatic wait_tx();
      int n;
      n = 0;
      while (!tx_enable && n < 200) begin
         step(0, '0, 0, 0);
         n++;
      end
      chk("wait_tx_timeout", int'(tx_enable), 1);
   endtask

   initial begin
      int f0;
      repeat (3) step(0, '0, 0, 1);
      started = 1;
      idle(2);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_ready", int'(in_ready), 1);
      // single frame
      f0 = frames;
      step(1, 9'h1A5, 0, 0);
      idle(PERIOD + 10);
      chk("t1_frames", frames - f0, 1);
      // three back-to-back words
      f0 = frames;
      step(1, 9'h001, 0, 0);
      step(1, 9'h0FF, 0, 0);
      step(1, 9'h1FF, 0, 0);
      idle(3 * PERIOD + 5);
      chk("t2_frames", frames - f0, 3);
      // overfill while a frame is in flight, then keep pushing across pops
      f0 = frames;
      step(1, 9'($urandom), 0, 0);
      idle(2);
      repeat (9) step(1, 9'($urandom), 0, 0);
      chk("t3_full_count", int'(fifo_count), DEPTH);
      chk("t3_full_ready", int'(in_ready), 0);
      idle(3);
      chk("t3_frames_blocked", frames - f0, 1);
      repeat (2 * PERIOD) step(1, 9'($urandom), 0, 0);
      idle((DEPTH + 2) * PERIOD);
      chk("t3_drained", int'(fifo_count), 0);
      // flush during the first of four frames
      f0 = frames;
      repeat (4) step(1, 9'($urandom), 0, 0);
      wait_tx();
      step(0, '0, 1, 0);
      chk("t4_flushed", int'(fifo_count), 0);
      idle(3 * PERIOD);
      chk("t4_frames", frames - f0, 1);
      // reset in the middle of a frame
      step(1, 9'($urandom), 0, 0);
      step(1, 9'($urandom), 0, 0);
      wait_tx();
      idle(5);
      step(0, '0, 0, 1);
      chk("t5_rst_en", int'(tx_enable), 0);
      chk("t5_rst_count", int'(fifo_count), 0);
      f0 = frames;
      step(1, 9'h155, 0, 0);
      idle(PERIOD + 5);
      chk("t5_frames", frames - f0, 1);
      // random traffic with occasional flush and reset
      repeat (1500) step($urandom % 3 != 0, 9'($urandom), $urandom % 97 == 0, $urandom % 301 == 0);
      idle((DEPTH + 1) * PERIOD + 10);
      chk("sb_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
